// File: rtl/tdm_voice_mixer.sv
// tdm_voice_mixer
// End-of-pipeline mixer for the TDM voice stream. One sample arrives per
// valid beat in channel order 0..NUM_VOICES-1. Enabled voices are summed
// over a frame. The sum is normalised by the active-voice count with a
// rounded reciprocal multiply and saturated, giving one mixed sample per
// frame.
//
// Handshake: an input beat is consumed on every rising edge where
// tdm_valid=1; there is no backpressure. mix_valid is a one-cycle strobe
// marking the cycle in which mix_out/active_voices take a new value; both
// hold until the next strobe.
//
// Optional feature: define TDM_MIX_MASTER_GAIN_EN to add a Q1.7 master-gain
// stage after saturation. This adds one cycle of latency.
//
// dbg_seq_state exposes the sequencer FSM state (0 = run, 1 = resync).

module tdm_voice_mixer #(
  parameter int D_W        = 16,
  parameter int NUM_VOICES = 8,
  parameter int VOICE_BITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  tdm_valid,
  input  logic [VOICE_BITS-1:0] tdm_channel_num,
  input  logic [D_W-1:0]        tdm_data_in,
  input  logic                  tdm_voice_en,
  input  logic [7:0]            master_gain,
  output logic [D_W-1:0]        mix_out,
  output logic                  mix_valid,
  output logic [VOICE_BITS:0]   active_voices,
  output logic                  seq_err,
  output logic                  dbg_seq_state
);

  localparam int ACC_W  = D_W + VOICE_BITS;
  localparam int REC_W  = 18;                // 17-bit reciprocal plus a zero sign bit
  localparam int PROD_W = ACC_W + REC_W;

  localparam logic [VOICE_BITS-1:0]    LAST_CH = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(32768);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (D_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  // round(2^16 / k); entry 0 yields 0 so an empty frame mixes to silence.
  function automatic logic [16:0] recip_lut(input logic [VOICE_BITS:0] k);
    logic [4:0] kk;
    kk = 5'(k);
    case (kk)
      5'd1:    recip_lut = 17'd65536;
      5'd2:    recip_lut = 17'd32768;
      5'd3:    recip_lut = 17'd21845;
      5'd4:    recip_lut = 17'd16384;
      5'd5:    recip_lut = 17'd13107;
      5'd6:    recip_lut = 17'd10923;
      5'd7:    recip_lut = 17'd9362;
      5'd8:    recip_lut = 17'd8192;
      5'd9:    recip_lut = 17'd7282;
      5'd10:   recip_lut = 17'd6554;
      5'd11:   recip_lut = 17'd5958;
      5'd12:   recip_lut = 17'd5461;
      5'd13:   recip_lut = 17'd5041;
      5'd14:   recip_lut = 17'd4681;
      5'd15:   recip_lut = 17'd4369;
      5'd16:   recip_lut = 17'd4096;
      default: recip_lut = 17'd0;
    endcase
  endfunction

  typedef enum logic {
    ST_RUN    = 1'b0,   // accepting beats in channel order
    ST_RESYNC = 1'b1    // after an order error, waiting for the next channel 0
  } seq_state_t;

  seq_state_t               state, state_n;
  logic [VOICE_BITS-1:0]    exp_ch, exp_ch_n;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic [VOICE_BITS:0]      cnt, cnt_n;
  logic                     seq_err_n;
  logic                     accept;
  logic                     frame_close;
  logic                     is_ch0;
  logic signed [ACC_W-1:0]  data_ext;
  logic signed [ACC_W-1:0]  beat_acc;
  logic [VOICE_BITS:0]      beat_cnt;

  assign dbg_seq_state = state;

  // Sequencer registers: FSM state, expected channel, running sum and count.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= ST_RUN;
      exp_ch  <= '0;
      acc     <= '0;
      cnt     <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_n;
      exp_ch  <= exp_ch_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      seq_err <= seq_err_n;
    end
  end

  // Sequencer next state: check channel order, load on channel 0, add otherwise.
  always_comb begin
    state_n   = state;
    exp_ch_n  = exp_ch;
    acc_n     = acc;
    cnt_n     = cnt;
    seq_err_n = 1'b0;
    accept    = 1'b0;
    is_ch0    = (tdm_channel_num == '0);
    data_ext  = {{VOICE_BITS{tdm_data_in[D_W-1]}}, tdm_data_in};
    beat_acc  = (is_ch0 ? '0 : acc) + (tdm_voice_en ? data_ext : '0);
    beat_cnt  = (is_ch0 ? '0 : cnt) + {{VOICE_BITS{1'b0}}, tdm_voice_en};
    if (tdm_valid) begin
      case (state)
        ST_RUN: begin
          if (tdm_channel_num == exp_ch) begin
            accept = 1'b1;
          end else begin
            seq_err_n = 1'b1;
            if (is_ch0) begin
              // An unexpected channel 0 is itself the start of a fresh frame.
              accept = 1'b1;
            end else begin
              state_n  = ST_RESYNC;
              exp_ch_n = '0;
            end
          end
        end
        ST_RESYNC: begin
          if (is_ch0) begin
            accept  = 1'b1;
            state_n = ST_RUN;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
    if (accept) begin
      acc_n = beat_acc;
      cnt_n = beat_cnt;
      if (tdm_channel_num == LAST_CH) exp_ch_n = '0;
      else                            exp_ch_n = tdm_channel_num + 1'b1;
    end
    frame_close = accept && (tdm_channel_num == LAST_CH);
  end

  // Stage 1: closed-frame sum and count.
  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_sum;
  logic [VOICE_BITS:0]     s1_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= frame_close;
      if (frame_close) begin
        s1_sum <= acc_n;
        s1_cnt <= cnt_n;
      end
    end
  end

  // Stage 2: sum times reciprocal of the voice count.
  logic                     s2_valid;
  logic signed [PROD_W-1:0] s2_prod;
  logic [VOICE_BITS:0]      s2_cnt;
  logic signed [PROD_W-1:0] prod_c;

  // Both operands widened to the product width so the low bits equal the signed product.
  always_comb begin
    prod_c = {{(PROD_W-ACC_W){s1_sum[ACC_W-1]}}, s1_sum}
           * PROD_W'({1'b0, recip_lut(s1_cnt)});
  end

  // Stage 2 register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_cnt   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= prod_c;
        s2_cnt  <= s1_cnt;
      end
    end
  end

  // Round half up, drop the 16 fraction bits, clamp to the sample range.
  logic signed [PROD_W-1:0] rnd_c, shf_c;
  logic [D_W-1:0]           sat_c;

  always_comb begin
    rnd_c = s2_prod + HALF;
    shf_c = rnd_c >>> 16;
    if (shf_c > SAT_MAX)      sat_c = SAT_MAX[D_W-1:0];
    else if (shf_c < SAT_MIN) sat_c = SAT_MIN[D_W-1:0];
    else                      sat_c = shf_c[D_W-1:0];
  end

`ifdef TDM_MIX_MASTER_GAIN_EN
  localparam int G_W = D_W + 9;
  localparam logic signed [G_W-1:0] G_MAX = G_W'((1 << (D_W - 1)) - 1);
  localparam logic signed [G_W-1:0] G_MIN = ~G_MAX;

  logic                  s3_valid;
  logic [D_W-1:0]        s3_mix;
  logic [VOICE_BITS:0]   s3_cnt;
  logic signed [G_W-1:0] g_prod, g_rnd, g_shf;
  logic [D_W-1:0]        g_sat;

  // Stage 3: normalised mix awaiting the gain multiply.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s3_valid <= 1'b0;
      s3_mix   <= '0;
      s3_cnt   <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_mix <= sat_c;
        s3_cnt <= s2_cnt;
      end
    end
  end

  // Q1.7 gain with round half up and clamp; master_gain is taken live here.
  always_comb begin
    g_prod = {{9{s3_mix[D_W-1]}}, s3_mix} * G_W'({1'b0, master_gain});
    g_rnd  = g_prod + G_W'(64);
    g_shf  = g_rnd >>> 7;
    if (g_shf > G_MAX)      g_sat = G_MAX[D_W-1:0];
    else if (g_shf < G_MIN) g_sat = G_MIN[D_W-1:0];
    else                    g_sat = g_shf[D_W-1:0];
  end

  // Stage 4: output register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mix_valid     <= 1'b0;
      mix_out       <= '0;
      active_voices <= '0;
    end else begin
      mix_valid <= s3_valid;
      if (s3_valid) begin
        mix_out       <= g_sat;
        active_voices <= s3_cnt;
      end
    end
  end
`else
  // Gain stage absent: the port stays for a uniform pin-out but is not used.
  logic unused_master_gain;
  assign unused_master_gain = ^master_gain;

  // Stage 3: output register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mix_valid     <= 1'b0;
      mix_out       <= '0;
      active_voices <= '0;
    end else begin
      mix_valid <= s2_valid;
      if (s2_valid) begin
        mix_out       <= sat_c;
        active_voices <= s2_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/tdm_voice_mixer.md
# tdm_voice_mixer

Parametrised end-of-pipeline mixer for the time-division-multiplexed voice pipeline. It accepts one voice sample per valid beat in channel order 0..NUM_VOICES-1 and accumulates the enabled voices over each frame. It then normalises the frame sum by the number of active voices, using a reciprocal multiply with rounding and saturation, and emits one mixed sample per frame to the output/DAC stage. Frame-sequence checking and an optional master-gain stage are included.

## Interface
- D_W, 16, sample width (signed two's complement)
- NUM_VOICES, 8, voices per TDM frame (2..16)
- VOICE_BITS, 3, clog2(NUM_VOICES)
- sys_clk  in  1  pipeline clock, all logic on rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- tdm_valid  in  1  beat qualifier; beats with tdm_valid=0 are ignored (gaps allowed)
- tdm_channel_num  in  VOICE_BITS  channel of current beat
- tdm_data_in  in  D_W  signed voice sample
- tdm_voice_en  in  1  voice active this beat
- master_gain  in  8  unsigned Q1.7 gain (0x80 = 1.0); used only with TDM_MIX_MASTER_GAIN_EN
- mix_out  out  D_W  signed normalised mix, held between updates
- mix_valid  out  1  one-cycle pulse when mix_out updates
- active_voices  out  VOICE_BITS+1  enabled-voice count of the emitted frame
- seq_err  out  1  one-cycle pulse on a channel-order violation

## Operation
- Sequencer: expected-channel counter exp_ch, starting at 0. A valid beat with tdm_channel_num == exp_ch is accepted and exp_ch increments. It wraps to 0 after NUM_VOICES-1.
- Accepting channel 0 loads the accumulator; later accepted beats add to it. A disabled beat contributes 0 and is not counted.
- Accumulator: signed, D_W+VOICE_BITS bits, sign-extended adds, never overflows. Count: VOICE_BITS+1 bits.
- Mismatch on a valid beat: pulse seq_err, discard the partial frame, emit no mix_valid for it.
  - If the offending channel is 0, it starts a new frame.
  - Otherwise, wait for the next channel 0.
- Frame close: acceptance of channel NUM_VOICES-1 latches sum and count into stage 1. The accumulator restarts on the next channel 0, so back-to-back frames need no idle beat.
- Normalise:
  - recip[k] = round(2^16/k), an unsigned 17-bit ROM; recip[0] = 0.
  - prod = sum*recip + 2^15, then arithmetic shift right by 16 (round half up).
  - Saturate to [-2^(D_W-1), 2^(D_W-1)-1].
  - Count 0 yields mix_out = 0 with mix_valid still pulsed.
- Stages are fully pipelined. A new frame may enter every NUM_VOICES accepted beats without stalls.

## Timing
- T = cycle in which the final beat (channel NUM_VOICES-1) is sampled.
- T+1: sum/count registered. T+2: product registered. T+3: mix_out, active_voices, mix_valid update (T+4 with gain stage).
- seq_err is asserted the cycle after the offending beat.
- Reset values: mix_out=0, mix_valid=0, active_voices=0, seq_err=0. Accumulator, count, exp_ch and all pipeline valids are cleared.
- Reset mid-frame or mid-pipeline: in-flight frames are discarded with no mix_valid. The first valid beat after deassertion must be channel 0.
- tdm_valid low on the last beat delays frame close; the partial frame is held indefinitely.

## Configuration
- TDM_MIX_MASTER_GAIN_EN defined:
  - Adds a stage after saturation: out = sat((mix * master_gain + 64) >>> 7).
  - Latency becomes T+4.
  - master_gain is sampled in the same cycle as the multiply.
- Undefined: master_gain is ignored (port still present), latency T+3, no gain multiplier inferred.

## Test plan
- All 8 voices enabled, each 1000: mix_out=1000, active_voices=8, mix_valid at T+3. With macro defined and master_gain=0x40: mix_out=500 at T+4.
- Voices 0,2,4 enabled at 3000; others disabled carrying 12345: mix_out=3000 (rounding exercised: 9000*21845), active_voices=3.
- No voice enabled: mix_out=0, active_voices=0, mix_valid pulses once.
- Voices 0..5 enabled at 32767, 6..7 disabled: pre-saturation 32768, so mix_out=32767. Same with -32768: mix_out=-32768.
- Channels 0,1,2,5: seq_err pulse the cycle after beat 5, no mix_valid. Next clean frame of 7 voices at -200: mix_out=-200, active_voices=7.
- Reset asserted for 2 cycles after channel 3 of a frame, then one clean 8-voice frame at 50: exactly one mix_valid, mix_out=50, no stale output from the aborted frame.
